// File: rtl/extmem_bridge.sv
// extmem_bridge: one 32-bit word request as one or two 16-bit external bus phases.
// Optional per-phase watchdog with err reporting: define EXTMEM_TIMEOUT_EN.
module extmem_bridge #(
  parameter int unsigned WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] adr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  input  logic        rwb,
  input  logic        en,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic [30:0] xadr,
  output logic [15:0] xdout,
  input  logic [15:0] xdin,
  output logic [1:0]  xbe,
  output logic        xwe,
  output logic        xcs,
  input  logic        xrdy
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [29:0] r_adr, r_adr_n;
  logic [31:0] r_wd, r_wd_n;
  logic [3:0]  r_be, r_be_n;
  logic        r_rwb, r_rwb_n;
  logic [31:0] rdata_n;
  logic        done_n, err_n;
  logic [30:0] xadr_n;
  logic [15:0] xdout_n;
  logic [1:0]  xbe_n;
  logic        xwe_n, xcs_n;
  logic        in_ph, fin, ent, abort;
`ifdef EXTMEM_TIMEOUT_EN
  logic [7:0]  wd, wd_n;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    r_adr_n = r_adr;
    r_wd_n  = r_wd;
    r_be_n  = r_be;
    r_rwb_n = r_rwb;
    rdata_n = rdata;
    abort   = 1'b0;
    in_ph   = (state == LO) || (state == HI);
    fin     = in_ph && (cnt == 4'd0) && xrdy;
`ifdef EXTMEM_TIMEOUT_EN
    wd_n = wd;
    if (in_ph && !xrdy) begin
      wd_n  = wd + 8'd1;
      abort = (wd == 8'd254);
    end
`endif
    unique case (state)
      IDLE: begin
        if (en) begin
          r_adr_n = adr;
          r_wd_n  = wdata;
          r_be_n  = byteen;
          r_rwb_n = rwb;
          if (rwb)
            state_n = LO;
          else if (byteen == 4'd0)
            state_n = DONE;
          else if (byteen[1:0] == 2'd0)
            state_n = HI;
          else
            state_n = LO;
        end
      end
      LO: begin
        if (abort) begin
          state_n = DONE;
        end else if (fin) begin
          if (r_rwb)
            rdata_n[15:0] = xdin;
          if (!r_rwb && r_be[3:2] == 2'd0)
            state_n = DONE;
          else
            state_n = HI;
        end
      end
      HI: begin
        if (abort) begin
          state_n = DONE;
        end else if (fin) begin
          if (r_rwb)
            rdata_n[31:16] = xdin;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
    endcase

    // counter restarts on every phase entry, including LO -> HI
    ent = (state_n == LO || state_n == HI) && (state_n != state);
    if (ent)
      cnt_n = 4'(WAIT);
    else if (in_ph && cnt != 4'd0)
      cnt_n = cnt - 4'd1;
`ifdef EXTMEM_TIMEOUT_EN
    if (ent)
      wd_n = 8'd0;
`endif

    done_n  = (state_n == DONE);
    err_n   = abort;
    xcs_n   = (state_n == LO) || (state_n == HI);
    xwe_n   = xcs_n && !r_rwb_n;
    xadr_n  = xadr;
    xdout_n = xdout;
    xbe_n   = xbe;
    if (state_n == LO) begin
      xadr_n  = {r_adr_n, 1'b0};
      xdout_n = r_wd_n[15:0];
      xbe_n   = r_rwb_n ? 2'b11 : r_be_n[1:0];
    end else if (state_n == HI) begin
      xadr_n  = {r_adr_n, 1'b1};
      xdout_n = r_wd_n[31:16];
      xbe_n   = r_rwb_n ? 2'b11 : r_be_n[3:2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      r_adr <= '0;
      r_wd  <= '0;
      r_be  <= '0;
      r_rwb <= 1'b0;
      rdata <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      xadr  <= '0;
      xdout <= '0;
      xbe   <= '0;
      xwe   <= 1'b0;
      xcs   <= 1'b0;
`ifdef EXTMEM_TIMEOUT_EN
      wd    <= 8'd0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      r_adr <= r_adr_n;
      r_wd  <= r_wd_n;
      r_be  <= r_be_n;
      r_rwb <= r_rwb_n;
      rdata <= rdata_n;
      done  <= done_n;
      err   <= err_n;
      xadr  <= xadr_n;
      xdout <= xdout_n;
      xbe   <= xbe_n;
      xwe   <= xwe_n;
      xcs   <= xcs_n;
`ifdef EXTMEM_TIMEOUT_EN
      wd    <= wd_n;
`endif
    end
  end

endmodule

// File: tb/tb_extmem_bridge.sv
// tb_extmem_bridge: directed requests against WAIT=0 and WAIT=2 bridges,
// with expected done/bus-phase records queued and checked by a monitor.
module tb_extmem_bridge;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          issue;
  } resp_t;

  typedef struct {
    logic [30:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    logic        we;
    int          len;
  } ph_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] adr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic        rwb, en, sel, xrdy;
  logic        en0, en2;

  logic [31:0] rdata0, rdata2;
  logic        done0, done2, err0, err2;
  logic [30:0] xadr0, xadr2;
  logic [15:0] xdout0, xdout2, xdin0, xdin2;
  logic [1:0]  xbe0, xbe2;
  logic        xwe0, xwe2, xcs0, xcs2;

  logic [31:0] m_rdata;
  logic        m_done, m_err, m_xwe, m_xcs;
  logic [30:0] m_xadr;
  logic [15:0] m_xdout;
  logic [1:0]  m_xbe;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  resp_t respq[$];
  ph_t   phq[$];
  ph_t   cur;
  bit    in_ph = 0;

  function automatic logic [15:0] hw(input logic [30:0] a);
    case (a)
      31'h95A: hw = 16'h2121;
      31'h95B: hw = 16'h4321;
      default: hw = a[15:0] ^ 16'hA5A5;
    endcase
  endfunction

  assign en0   = en & ~sel;
  assign en2   = en & sel;
  assign xdin0 = hw(xadr0);
  assign xdin2 = hw(xadr2);

  assign m_rdata = sel ? rdata2 : rdata0;
  assign m_done  = sel ? done2  : done0;
  assign m_err   = sel ? err2   : err0;
  assign m_xadr  = sel ? xadr2  : xadr0;
  assign m_xdout = sel ? xdout2 : xdout0;
  assign m_xbe   = sel ? xbe2   : xbe0;
  assign m_xwe   = sel ? xwe2   : xwe0;
  assign m_xcs   = sel ? xcs2   : xcs0;

  extmem_bridge #(.WAIT(0)) u0 (
    .clk(clk), .reset(reset), .adr(adr), .wdata(wdata),
    .byteen(byteen), .rwb(rwb), .en(en0), .rdata(rdata0),
    .done(done0), .err(err0), .xadr(xadr0), .xdout(xdout0),
    .xdin(xdin0), .xbe(xbe0), .xwe(xwe0), .xcs(xcs0), .xrdy(xrdy)
  );

  extmem_bridge #(.WAIT(2)) u2 (
    .clk(clk), .reset(reset), .adr(adr), .wdata(wdata),
    .byteen(byteen), .rwb(rwb), .en(en2), .rdata(rdata2),
    .done(done2), .err(err2), .xadr(xadr2), .xdout(xdout2),
    .xdin(xdin2), .xbe(xbe2), .xwe(xwe2), .xcs(xcs2), .xrdy(xrdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    resp_t r;
    ph_t   p;
    int    lat;
    if (m_done) begin
      total++;
      if (respq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: rdata=%h err=%b", m_rdata, m_err);
      end else begin
        r   = respq.pop_front();
        lat = cyc - r.issue + 1;
        if (m_rdata !== r.rd || m_err !== r.er || lat != r.lat) begin
          bad++;
          $display("FAIL done: got rdata=%h err=%b cycle=%0d want rdata=%h err=%b cycle=%0d",
                   m_rdata, m_err, lat, r.rd, r.er, r.lat);
        end
      end
    end
    if (in_ph && (!m_xcs || m_xadr != cur.a)) begin
      total++;
      if (phq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_phase: xadr=%h len=%0d", cur.a, cur.len);
      end else begin
        p = phq.pop_front();
        if (cur.a !== p.a || cur.d !== p.d || cur.be !== p.be ||
            cur.we !== p.we || cur.len != p.len) begin
          bad++;
          $display("FAIL phase: got xadr=%h xdout=%h xbe=%b xwe=%b len=%0d want %h %h %b %b %0d",
                   cur.a, cur.d, cur.be, cur.we, cur.len,
                   p.a, p.d, p.be, p.we, p.len);
        end
      end
      in_ph = 0;
    end
    if (m_xcs && !in_ph) begin
      in_ph  = 1;
      cur.a  = m_xadr;
      cur.d  = m_xdout;
      cur.be = m_xbe;
      cur.we = m_xwe;
      cur.len = 0;
    end
    if (in_ph)
      cur.len++;
  end

  task automatic push_ph(input logic [30:0] a, input logic [15:0] d,
                         input logic [1:0] be, input logic we, input int len);
    ph_t p;
    p.a = a; p.d = d; p.be = be; p.we = we; p.len = len;
    phq.push_back(p);
  endtask

  task automatic do_req(input bit s, input logic [29:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic rw, input int stall,
                        input int lo_len, input int hi_len, input int lat,
                        input logic [31:0] rd, input logic er);
    resp_t r;
    int    n;
    bit    got;
    @(negedge clk);
    sel = s;
    adr = a; wdata = wd; byteen = be; rwb = rw; en = 1'b1; xrdy = 1'b1;
    r.rd = rd; r.er = er; r.lat = lat; r.issue = cyc + 1;
    respq.push_back(r);
    if (lo_len > 0)
      push_ph({a, 1'b0}, wd[15:0], rw ? 2'b11 : be[1:0], ~rw, lo_len);
    if (hi_len > 0)
      push_ph({a, 1'b1}, wd[31:16], rw ? 2'b11 : be[3:2], ~rw, hi_len);
    n = 0;
    got = 0;
    while (!got && n < 600) begin
      @(negedge clk);
      n++;
      if (m_done)
        got = 1;
      else if (m_xcs && stall > 0) begin
        xrdy = 1'b0;
        stall--;
      end else
        xrdy = 1'b1;
    end
    en = 1'b0;
    xrdy = 1'b1;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL req_timeout: no done for adr=%h after %0d cycles", a, n);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sel = 1'b0; xrdy = 1'b1;
    adr = '0; wdata = '0; byteen = '0; rwb = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({rdata0, done0, err0, xadr0, xdout0, xbe0, xwe0, xcs0} !== '0) begin
      bad++;
      $display("FAIL reset_u0: got %h %b %b %h %h %b %b %b want all 0",
               rdata0, done0, err0, xadr0, xdout0, xbe0, xwe0, xcs0);
    end
    total++;
    if ({rdata2, done2, err2, xadr2, xdout2, xbe2, xwe2, xcs2} !== '0) begin
      bad++;
      $display("FAIL reset_u2: got %h %b %b %h %h %b %b %b want all 0",
               rdata2, done2, err2, xadr2, xdout2, xbe2, xwe2, xcs2);
    end
    reset = 1'b0;

    //     sel adr      wdata         be     rw  stall lo hi lat rdata         err
    do_req(0, 30'h4AD, 32'h0,        4'hF,  1,  0,    1, 1, 3, 32'h43212121, 0);
    do_req(1, 30'h055, 32'hDDCCBBAA, 4'hF,  0,  0,    3, 3, 7, 32'h0,        0);
    do_req(0, 30'h100, 32'h12345678, 4'hC,  0,  0,    0, 1, 2, 32'h43212121, 0);
    do_req(0, 30'h101, 32'h9ABCDEF0, 4'h3,  0,  0,    1, 0, 2, 32'h43212121, 0);
    do_req(0, 30'h102, 32'h11111111, 4'h0,  0,  0,    0, 0, 1, 32'h43212121, 0);
    do_req(0, 30'h010, 32'h0,        4'h0,  1,  5,    6, 1, 8, 32'hA584A585, 0);
    do_req(1, 30'h4AD, 32'h0,        4'h5,  1,  0,    3, 3, 7, 32'h43212121, 0);
    do_req(0, 30'h007, 32'hCAFEF00D, 4'h5,  0,  0,    1, 1, 3, 32'hA584A585, 0);

    // reset lands in the HI phase of a write
    @(negedge clk);
    sel = 1'b0;
    adr = 30'h02A; wdata = 32'h5555AAAA; byteen = 4'hF; rwb = 1'b0; en = 1'b1;
    push_ph(31'h054, 16'hAAAA, 2'b11, 1'b1, 1);
    push_ph(31'h055, 16'h5555, 2'b11, 1'b1, 1);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    en = 1'b0;
    #1;
    total++;
    if (xcs0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_xcs: got %b want 0", xcs0);
    end
    total++;
    if (xwe0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_xwe: got %b want 0", xwe0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    do_req(0, 30'h02A, 32'h5555AAAA, 4'hF,  0,  0,    1, 1, 3, 32'h0,        0);
    do_req(0, 30'h003, 32'h0,        4'hF,  1,  0,    1, 1, 3, 32'hA5A2A5A3, 0);
`ifdef EXTMEM_TIMEOUT_EN
    do_req(0, 30'h200, 32'h0,        4'hF,  1,  1000, 255, 0, 256, 32'hA5A2A5A3, 1);
    do_req(0, 30'h4AD, 32'h0,        4'hF,  1,  0,    1, 1, 3, 32'h43212121, 0);
`endif

    repeat (5) @(negedge clk);
    total++;
    if (respq.size() != 0 || phq.size() != 0) begin
      bad++;
      $display("FAIL leftover: got resp=%0d phase=%0d want 0 0",
               respq.size(), phq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
